// File: rtl/bank_account_server_if.sv
// Request/response channel between the ATM controller (master) and the bank server (slave).
interface bank_account_server_if #(
  parameter int CARD_W = 8,
  parameter int PIN_W  = 4,
  parameter int BAL_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [CARD_W-1:0] req_cardno;
  logic [PIN_W-1:0]  req_pin;
  logic [BAL_W-1:0]  req_amount;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2:0]        rsp_status;
  logic [BAL_W-1:0]  rsp_balance;

  modport master (
    output req_valid, req_op, req_cardno, req_pin, req_amount, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_balance
  );

  modport slave (
    input  req_valid, req_op, req_cardno, req_pin, req_amount, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_balance
  );
endinterface

// File: rtl/bank_account_server.sv
// Bank-side account table: linear card search, PIN check with lockout, and
// deposit/withdraw/query against the authoritative balance.
//
// state  | meaning
// IDLE   | accepting provisioning writes or a new ATM request
// SEARCH | scanning one table entry per cycle for the captured card
// EXEC   | applying lock/PIN/op rules to the hit entry
// RESP   | holding the response until the ATM takes it
module bank_account_server #(
  parameter int NUM_ACCTS  = 8,
  parameter int CARD_W     = 8,
  parameter int PIN_W      = 4,
  parameter int BAL_W      = 5,
  parameter int LOCK_LIMIT = 3,
  localparam int IDX_W     = $clog2(NUM_ACCTS),
  localparam int CNT_W     = $clog2(LOCK_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  bank_account_server_if.slave bus,
  input  logic              prog_en,
  input  logic [IDX_W-1:0]  prog_idx,
  input  logic [CARD_W-1:0] prog_cardno,
  input  logic [PIN_W-1:0]  prog_pin,
  input  logic [BAL_W-1:0]  prog_balance
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_EXEC, S_RESP} state_t;

  localparam logic [1:0] OP_VERIFY   = 2'b00;
  localparam logic [1:0] OP_DEPOSIT  = 2'b01;
  localparam logic [1:0] OP_WITHDRAW = 2'b10;

  localparam logic [2:0] ST_OK           = 3'b000;
  localparam logic [2:0] ST_NOT_FOUND    = 3'b001;
  localparam logic [2:0] ST_BAD_PIN      = 3'b010;
  localparam logic [2:0] ST_LOCKED       = 3'b011;
  localparam logic [2:0] ST_INSUFFICIENT = 3'b100;
  localparam logic [2:0] ST_OVERFLOW     = 3'b101;
  localparam logic [2:0] ST_BAD_AMOUNT   = 3'b110;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACCTS - 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(LOCK_LIMIT);

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [CARD_W-1:0] card_q, card_d;
  logic [PIN_W-1:0]  pin_q, pin_d;
  logic [BAL_W-1:0]  amt_q, amt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [2:0]        status_q, status_d;
  logic [BAL_W-1:0]  rbal_q, rbal_d;

  logic [NUM_ACCTS-1:0] valid_q, valid_d;
  logic [NUM_ACCTS-1:0] lock_q, lock_d;
  logic [CNT_W-1:0]     cnt_q   [NUM_ACCTS];
  logic [CNT_W-1:0]     cnt_d   [NUM_ACCTS];
  logic [CARD_W-1:0]    acard_q [NUM_ACCTS];
  logic [CARD_W-1:0]    acard_d [NUM_ACCTS];
  logic [PIN_W-1:0]     apin_q  [NUM_ACCTS];
  logic [PIN_W-1:0]     apin_d  [NUM_ACCTS];
  logic [BAL_W-1:0]     abal_q  [NUM_ACCTS];
  logic [BAL_W-1:0]     abal_d  [NUM_ACCTS];

  logic [BAL_W:0] sum;
  logic           hit;

  assign bus.req_ready   = (state_q == S_IDLE) && !prog_en;
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_status  = status_q;
  assign bus.rsp_balance = rbal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      card_q   <= '0;
      pin_q    <= '0;
      amt_q    <= '0;
      idx_q    <= '0;
      status_q <= ST_OK;
      rbal_q   <= '0;
      valid_q  <= '0;
      lock_q   <= '0;
      cnt_q    <= '{default: '0};
      acard_q  <= '{default: '0};
      apin_q   <= '{default: '0};
      abal_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      card_q   <= card_d;
      pin_q    <= pin_d;
      amt_q    <= amt_d;
      idx_q    <= idx_d;
      status_q <= status_d;
      rbal_q   <= rbal_d;
      valid_q  <= valid_d;
      lock_q   <= lock_d;
      cnt_q    <= cnt_d;
      acard_q  <= acard_d;
      apin_q   <= apin_d;
      abal_q   <= abal_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    card_d   = card_q;
    pin_d    = pin_q;
    amt_d    = amt_q;
    idx_d    = idx_q;
    status_d = status_q;
    rbal_d   = rbal_q;
    valid_d  = valid_q;
    lock_d   = lock_q;
    cnt_d    = cnt_q;
    acard_d  = acard_q;
    apin_d   = apin_q;
    abal_d   = abal_q;

    // Extra bit catches deposit overflow without wrapping.
    sum = {1'b0, abal_q[idx_q]} + {1'b0, amt_q};
    hit = valid_q[idx_q] && (acard_q[idx_q] != '0) && (acard_q[idx_q] == card_q);

    case (state_q)
      S_IDLE: begin
        if (prog_en) begin
          if (int'(prog_idx) < NUM_ACCTS) begin
            valid_d[prog_idx] = (prog_cardno != '0);
            lock_d[prog_idx]  = 1'b0;
            cnt_d[prog_idx]   = '0;
            acard_d[prog_idx] = prog_cardno;
            apin_d[prog_idx]  = prog_pin;
            abal_d[prog_idx]  = prog_balance;
          end
        end else if (bus.req_valid) begin
          op_d    = bus.req_op;
          card_d  = bus.req_cardno;
          pin_d   = bus.req_pin;
          amt_d   = bus.req_amount;
          idx_d   = '0;
          state_d = S_SEARCH;
        end
      end

      S_SEARCH: begin
        if (hit) begin
          state_d = S_EXEC;
        end else if (idx_q == LAST_IDX) begin
          status_d = ST_NOT_FOUND;
          rbal_d   = '0;
          state_d  = S_RESP;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_EXEC: begin
        state_d = S_RESP;
        if (lock_q[idx_q]) begin
          status_d = ST_LOCKED;
          rbal_d   = '0;
        end else if (apin_q[idx_q] != pin_q) begin
          if (cnt_q[idx_q] < LIMIT) cnt_d[idx_q] = cnt_q[idx_q] + CNT_W'(1);
          if (cnt_q[idx_q] >= LIMIT - CNT_W'(1)) lock_d[idx_q] = 1'b1;
          status_d = ST_BAD_PIN;
          rbal_d   = '0;
        end else begin
          cnt_d[idx_q] = '0;
          status_d     = ST_OK;
          rbal_d       = abal_q[idx_q];
          if (op_q == OP_DEPOSIT || op_q == OP_WITHDRAW) begin
            if (amt_q == '0) begin
              status_d = ST_BAD_AMOUNT;
            end else if (op_q == OP_DEPOSIT) begin
              if (sum[BAL_W]) begin
                status_d = ST_OVERFLOW;
              end else begin
                abal_d[idx_q] = sum[BAL_W-1:0];
                rbal_d        = sum[BAL_W-1:0];
              end
            end else if (amt_q > abal_q[idx_q]) begin
              status_d = ST_INSUFFICIENT;
            end else begin
              abal_d[idx_q] = abal_q[idx_q] - amt_q;
              rbal_d        = abal_q[idx_q] - amt_q;
            end
          end else if (op_q == OP_VERIFY) begin
            rbal_d = abal_q[idx_q];
          end
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bank_account_server.sv
// Scoreboard bench for bank_account_server: expected status/balance/latency
// are queued per request and popped when the response appears.
module tb_bank_account_server;

  localparam logic [1:0] OP_VER = 2'b00, OP_DEP = 2'b01, OP_WD = 2'b10, OP_QRY = 2'b11;
  localparam logic [2:0] ST_OK = 3'd0, ST_NF = 3'd1, ST_BADPIN = 3'd2, ST_LOCKED = 3'd3,
                         ST_INSUF = 3'd4, ST_OVF = 3'd5, ST_BADAMT = 3'd6;

  typedef struct {
    logic [2:0] st;
    logic [4:0] bal;
    int         lat;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [7:0] card;
    logic [3:0] pin;
    logic [4:0] amt;
    logic [2:0] st;
    logic [4:0] bal;
    int         lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog_en;
  logic [2:0] prog_idx;
  logic [7:0] prog_cardno;
  logic [3:0] prog_pin;
  logic [4:0] prog_balance;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  bank_account_server_if #(.CARD_W(8), .PIN_W(4), .BAL_W(5)) bus ();

  bank_account_server #(
    .NUM_ACCTS(8), .CARD_W(8), .PIN_W(4), .BAL_W(5), .LOCK_LIMIT(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .prog_en      (prog_en),
    .prog_idx     (prog_idx),
    .prog_cardno  (prog_cardno),
    .prog_pin     (prog_pin),
    .prog_balance (prog_balance)
  );

  always #5 clk = ~clk;

  task automatic program_acct(input logic [2:0] idx, input logic [7:0] card,
                              input logic [3:0] pin, input logic [4:0] bal);
    prog_en = 1'b1; prog_idx = idx; prog_cardno = card; prog_pin = pin; prog_balance = bal;
    @(posedge clk); #1;
    prog_en = 1'b0;
  endtask

  // Drives one request and returns what the DUT shows when rsp_valid first rises.
  task automatic do_req(input logic [1:0] op, input logic [7:0] card, input logic [3:0] pin,
                        input logic [4:0] amt, output logic [2:0] st, output logic [4:0] bal,
                        output int lat);
    int wait_cnt = 0;
    while (!bus.req_ready && wait_cnt < 20) begin
      @(posedge clk); #1; wait_cnt++;
    end
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_cardno = card;
    bus.req_pin = pin; bus.req_amount = amt;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = -1; st = 3'bx; bal = 5'bx;
    for (int n = 1; n <= 40; n++) begin
      if (bus.rsp_valid) break;
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        lat = n; st = bus.rsp_status; bal = bus.rsp_balance;
        break;
      end
    end
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
    checks++;
    if (bus.rsp_status !== ST_OK) begin errors++; $display("FAIL reset_status got %0d exp 0", bus.rsp_status); end
    checks++;
    if (bus.rsp_balance !== 5'd0) begin errors++; $display("FAIL reset_balance got %0d exp 0", bus.rsp_balance); end
    prog_en = 1'b1; prog_idx = 3'd2; prog_cardno = 8'h5A; prog_pin = 4'h7; prog_balance = 5'd10;
    bus.req_valid = 1'b1; bus.req_op = OP_VER; bus.req_cardno = 8'h5A;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL prog_priority_req_ready got %b exp 0", bus.req_ready); end
    @(posedge clk); #1;
    prog_en = 1'b0; bus.req_valid = 1'b0;
    // Duplicate card at a higher index must be shadowed by idx2.
    program_acct(3'd5, 8'h5A, 4'h1, 5'd3);
  endtask

  task automatic test_ops();
    vec_t v[$];
    exp_t e;
    logic [2:0] st;
    logic [4:0] bal;
    int lat;
    v.push_back('{OP_VER, 8'h5A, 4'h7, 5'd0,  ST_OK,     5'd10, 4});
    v.push_back('{OP_DEP, 8'h5A, 4'h7, 5'd21, ST_OK,     5'd31, 4});
    v.push_back('{OP_DEP, 8'h5A, 4'h7, 5'd1,  ST_OVF,    5'd31, 4});
    v.push_back('{OP_WD,  8'h5A, 4'h7, 5'd0,  ST_BADAMT, 5'd31, 4});
    v.push_back('{OP_WD,  8'h5A, 4'h7, 5'd31, ST_OK,     5'd0,  4});
    v.push_back('{OP_WD,  8'h5A, 4'h7, 5'd1,  ST_INSUF,  5'd0,  4});
    v.push_back('{OP_DEP, 8'h5A, 4'h7, 5'd0,  ST_BADAMT, 5'd0,  4});
    v.push_back('{OP_QRY, 8'h5A, 4'h7, 5'd0,  ST_OK,     5'd0,  4});
    foreach (v[i]) begin
      sb.push_back('{v[i].st, v[i].bal, v[i].lat});
      do_req(v[i].op, v[i].card, v[i].pin, v[i].amt, st, bal, lat);
      finish_rsp();
      e = sb.pop_front();
      checks++;
      if (st !== e.st) begin errors++; $display("FAIL ops[%0d]_status got %0d exp %0d", i, st, e.st); end
      checks++;
      if (bal !== e.bal) begin errors++; $display("FAIL ops[%0d]_balance got %0d exp %0d", i, bal, e.bal); end
      checks++;
      if (lat != e.lat) begin errors++; $display("FAIL ops[%0d]_latency got %0d exp %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_lock();
    vec_t v[$];
    exp_t e;
    logic [2:0] st;
    logic [4:0] bal;
    int lat;
    program_acct(3'd2, 8'h5A, 4'h7, 5'd10);
    // Two misses then a correct PIN must reset the streak before the real lockout run.
    v.push_back('{OP_VER, 8'h5A, 4'h3, 5'd0, ST_BADPIN, 5'd0,  4});
    v.push_back('{OP_VER, 8'h5A, 4'h3, 5'd0, ST_BADPIN, 5'd0,  4});
    v.push_back('{OP_VER, 8'h5A, 4'h7, 5'd0, ST_OK,     5'd10, 4});
    v.push_back('{OP_VER, 8'h5A, 4'h3, 5'd0, ST_BADPIN, 5'd0,  4});
    v.push_back('{OP_VER, 8'h5A, 4'h3, 5'd0, ST_BADPIN, 5'd0,  4});
    v.push_back('{OP_VER, 8'h5A, 4'h3, 5'd0, ST_BADPIN, 5'd0,  4});
    v.push_back('{OP_VER, 8'h5A, 4'h7, 5'd0, ST_LOCKED, 5'd0,  4});
    v.push_back('{OP_DEP, 8'h5A, 4'h7, 5'd5, ST_LOCKED, 5'd0,  4});
    foreach (v[i]) begin
      sb.push_back('{v[i].st, v[i].bal, v[i].lat});
      do_req(v[i].op, v[i].card, v[i].pin, v[i].amt, st, bal, lat);
      finish_rsp();
      e = sb.pop_front();
      checks++;
      if (st !== e.st || bal !== e.bal || lat != e.lat) begin
        errors++;
        $display("FAIL lock[%0d] got st=%0d bal=%0d lat=%0d exp st=%0d bal=%0d lat=%0d",
                 i, st, bal, lat, e.st, e.bal, e.lat);
      end
    end
    program_acct(3'd2, 8'h5A, 4'h7, 5'd10);
    sb.push_back('{ST_OK, 5'd10, 4});
    do_req(OP_VER, 8'h5A, 4'h7, 5'd0, st, bal, lat);
    finish_rsp();
    e = sb.pop_front();
    checks++;
    if (st !== e.st || bal !== e.bal) begin
      errors++; $display("FAIL unlock_by_reprogram got st=%0d bal=%0d exp st=%0d bal=%0d", st, bal, e.st, e.bal);
    end
  endtask

  task automatic test_search();
    vec_t v[$];
    exp_t e;
    logic [2:0] st;
    logic [4:0] bal;
    int lat;
    program_acct(3'd0, 8'h11, 4'h2, 5'd4);
    program_acct(3'd7, 8'h33, 4'h9, 5'd5);
    v.push_back('{OP_QRY, 8'h99, 4'h7, 5'd0, ST_NF, 5'd0, 8});
    v.push_back('{OP_VER, 8'h00, 4'h0, 5'd0, ST_NF, 5'd0, 8});
    v.push_back('{OP_QRY, 8'h11, 4'h2, 5'd0, ST_OK, 5'd4, 2});
    v.push_back('{OP_WD,  8'h33, 4'h9, 5'd5, ST_OK, 5'd0, 9});
    foreach (v[i]) begin
      sb.push_back('{v[i].st, v[i].bal, v[i].lat});
      do_req(v[i].op, v[i].card, v[i].pin, v[i].amt, st, bal, lat);
      finish_rsp();
      e = sb.pop_front();
      checks++;
      if (st !== e.st) begin errors++; $display("FAIL search[%0d]_status got %0d exp %0d", i, st, e.st); end
      checks++;
      if (bal !== e.bal) begin errors++; $display("FAIL search[%0d]_balance got %0d exp %0d", i, bal, e.bal); end
      checks++;
      if (lat != e.lat) begin errors++; $display("FAIL search[%0d]_latency got %0d exp %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [2:0] st;
    logic [4:0] bal;
    int lat;
    bus.rsp_ready = 1'b0;
    sb.push_back('{ST_OK, 5'd10, 4});
    do_req(OP_QRY, 8'h5A, 4'h7, 5'd0, st, bal, lat);
    e = sb.pop_front();
    checks++;
    if (st !== e.st || bal !== e.bal || lat != e.lat) begin
      errors++; $display("FAIL bp_first got st=%0d bal=%0d lat=%0d exp st=%0d bal=%0d lat=%0d",
                         st, bal, lat, e.st, e.bal, e.lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== e.st || bus.rsp_balance !== e.bal
          || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b st=%0d bal=%0d rdy=%b exp v=1 st=%0d bal=%0d rdy=0",
                 c, bus.rsp_valid, bus.rsp_status, bus.rsp_balance, bus.req_ready, e.st, e.bal);
      end
    end
    finish_rsp();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [2:0] st;
    logic [4:0] bal;
    int lat;
    bus.req_valid = 1'b1; bus.req_op = OP_WD; bus.req_cardno = 8'h5A;
    bus.req_pin = 4'h7; bus.req_amount = 5'd3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_rsp_valid got %b exp 0", bus.rsp_valid); end
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_hold_valid got %b exp 0", bus.rsp_valid); end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready got %b exp 1", bus.req_ready); end
    // Reset clears the table, so the card is gone.
    sb.push_back('{ST_NF, 5'd0, 8});
    do_req(OP_QRY, 8'h5A, 4'h7, 5'd0, st, bal, lat);
    finish_rsp();
    e = sb.pop_front();
    checks++;
    if (st !== e.st || bal !== e.bal || lat != e.lat) begin
      errors++; $display("FAIL midrst_table_cleared got st=%0d bal=%0d lat=%0d exp st=%0d bal=%0d lat=%0d",
                         st, bal, lat, e.st, e.bal, e.lat);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    prog_en = 1'b0; prog_idx = '0; prog_cardno = '0; prog_pin = '0; prog_balance = '0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_cardno = '0;
    bus.req_pin = '0; bus.req_amount = '0; bus.rsp_ready = 1'b1;
    test_reset();
    test_ops();
    test_lock();
    test_search();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bank_account_server.md
Name: bank_account_server

Overview:
- Bank-side responder for the ATM controller. It holds a small table of accounts, each with a card number, PIN, balance, failed-PIN counter and lock flag.
- It serves ATM transactions over a valid/ready request and response pair: PIN verify, deposit, withdraw and balance query.
- The ATM stays the initiator. This block checks PINs and owns the authoritative balance.
- A provisioning port loads accounts while the block is idle.

Parameters:
- NUM_ACCTS, 8, number of account entries (at least 2).
- CARD_W, 8, card number width.
- PIN_W, 4, PIN width.
- BAL_W, 5, balance and amount width (unsigned).
- LOCK_LIMIT, 3, consecutive wrong PINs that lock an account.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  ATM request valid.
- req_ready  out  1  server can accept a request.
- req_op  in  2  00 verify, 01 deposit, 10 withdraw, 11 balance query.
- req_cardno  in  CARD_W  card number.
- req_pin  in  PIN_W  entered PIN.
- req_amount  in  BAL_W  deposit or withdraw amount.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  ATM accepts the response.
- rsp_status  out  3  000 OK, 001 NOT_FOUND, 010 BAD_PIN, 011 LOCKED, 100 INSUFFICIENT, 101 OVERFLOW, 110 BAD_AMOUNT.
- rsp_balance  out  BAL_W  balance after the operation.
- prog_en  in  1  write one account entry.
- prog_idx  in  clog2(NUM_ACCTS)  entry index.
- prog_cardno  in  CARD_W  card number; 0 invalidates the entry.
- prog_pin  in  PIN_W  PIN.
- prog_balance  in  BAL_W  initial balance.

Behaviour:
- Reset (async assert, sync release):
  - all entries invalid; fail counters 0; lock flags 0;
  - state IDLE; req_ready=1; rsp_valid=0; rsp_status=000; rsp_balance=0.
- Reset mid-transaction aborts it. No table update is committed and no response is produced.
- FSM states: IDLE, SEARCH, EXEC, RESP.
- req_ready = (state==IDLE) && !prog_en. Provisioning takes priority over requests.
- IDLE:
  - prog_en: write entry prog_idx on the edge; clear its fail counter and lock flag. prog_idx >= NUM_ACCTS is ignored.
  - req_valid && req_ready: capture op, cardno, pin and amount; idx=0; go to SEARCH.
- SEARCH: examine one entry per cycle. An entry is a hit when it is valid, its cardno is nonzero and it equals the captured cardno.
  - Hit: latch idx and go to EXEC.
  - Miss with idx==NUM_ACCTS-1: status NOT_FOUND, balance 0, go to RESP.
  - Otherwise idx+1.
  - Duplicate card numbers: lowest index wins.
  - A request with cardno 0 is always NOT_FOUND.
- EXEC (one cycle), rules in priority order:
  1. Locked: status LOCKED, balance 0.
  2. PIN mismatch: fail counter +1, saturating at LOCK_LIMIT; lock flag set when it reaches LOCK_LIMIT. Status BAD_PIN, balance 0.
  3. PIN match: fail counter cleared, then the op is applied:
     - verify / query: OK, current balance.
     - deposit or withdraw with amount 0: BAD_AMOUNT, balance unchanged.
     - deposit: if balance+amount > 2^BAL_W-1, OVERFLOW and no change. Otherwise commit the sum, OK. Use a BAL_W+1-bit sum.
     - withdraw: if amount > balance, INSUFFICIENT and no change. Otherwise commit the difference, OK. Withdrawing to exactly 0 is allowed.
  - Go to RESP.
- RESP:
  - rsp_valid=1; status and balance held stable until rsp_valid && rsp_ready.
  - On that edge: rsp_valid=0 and state IDLE; req_ready rises the following cycle.
- Latency: request accepted at edge T and hit at index k gives rsp_valid high after edge T+k+2. A miss gives rsp_valid after edge T+NUM_ACCTS.
- Table writes occur only in EXEC or IDLE/prog, so there is never simultaneous access. prog_en outside IDLE is ignored.

Test Plan:
- Program idx2 = {card 0x5A, pin 4'h7, bal 10}. Request verify 0x5A, pin 7 at edge T, rsp_ready=1 → rsp_valid after T+4, status 000, balance 10.
- Same account, deposit 21 → OK, balance 31. Then deposit 1 → OVERFLOW, balance 31. Then withdraw 0 → BAD_AMOUNT, balance 31.
- Withdraw 31 → OK, balance 0. Then withdraw 1 → INSUFFICIENT, balance 0.
- Three verifies with pin 3 → BAD_PIN each time. Fourth request with pin 7 → LOCKED. Re-program idx2 → verify with pin 7 gives OK.
- Request card 0x99 (unprogrammed) → NOT_FOUND, balance 0, rsp_valid after T+8. Request card 0x00 → NOT_FOUND.
- Hold rsp_ready=0 for 5 cycles: rsp_valid/status/balance stable and req_ready=0. Assert rst_n=0 during SEARCH: rsp_valid=0 immediately, no balance change, req_ready=1 after release.
